shift_rp_controller: RTL and testbench
======================================

Name: shift_rp_controller

Overview:
- Sequences the two nested shift reconfigurable partitions (upper/lower) in the LED shift design.
- Generates the shared 12-bit address from a prescaled counter with run, single-step and direction control.
- Registers the RP data outputs to upper/lower and manages the DFX reconfiguration handshake: drain, decouple, wait for done, then reset the new RMs and resume.
- Sits between the static top-level and the shift RP instances.

Parameters:
- ADDR_W, 12, width of the address driven to both shift RPs.
- PRESCALE_W, 23, prescaler width; one address tick every 2^PRESCALE_W cycles.
- DRAIN_CYCLES, 4, cycles held in DRAIN before decouple asserts (range 1..255).
- RECOVER_CYCLES, 2, cycles rm_rst is held after decouple releases (range 1..255).
- TIMEOUT_CYCLES, 1024, decouple watchdog limit (optional feature only).

Ports:
- gclk  in  1  clock
- rst  in  1  asynchronous active-high reset
- run  in  1  level; free-running address advance while high
- step_req  in  1  pulse; one address step while in IDLE
- dir  in  1  0 = increment, 1 = decrement
- reconfig_req  in  1  pulse; request RP reconfiguration
- reconfig_done  in  1  pulse from the DFX controller; partial bitstream loaded
- upper_in  in  4  data_out of the upper shift RP
- lower_in  in  4  data_out of the lower shift RP
- addr  out  ADDR_W  address to both RPs
- rm_rst  out  1  enable/reset to both RPs
- decouple  out  1  DFX decoupler enable
- reconfig_ack  out  1  high while DECOUPLED; safe to reconfigure
- upper  out  4  registered upper data
- lower  out  4  registered lower data
- busy  out  1  high in DRAIN, DECOUPLED and RECOVER

Behaviour:
- Reset, asynchronous: state=IDLE, addr=0, prescaler=0, rm_rst=1, decouple=0, reconfig_ack=0, upper=0, lower=0, busy=0.
- rm_rst is registered and deasserts on the first gclk edge after rst falls.
- All outputs are registered.
- IDLE:
  - run=1 -> RUN.
  - step_req -> addr±1 on the next edge; prescaler stays 0.
  - reconfig_req -> DRAIN.
- RUN:
  - The prescaler increments every cycle.
  - When the prescaler is all-ones, addr±1 on the same edge and the prescaler wraps to 0.
  - run=0 -> IDLE: prescaler cleared, addr kept.
  - reconfig_req -> DRAIN; prescaler frozen.
- DRAIN:
  - Counts DRAIN_CYCLES, then -> DECOUPLED.
  - addr, upper and lower frozen.
- DECOUPLED:
  - decouple=1, reconfig_ack=1, upper/lower frozen.
  - reconfig_done -> RECOVER.
- RECOVER:
  - decouple=0, reconfig_ack=0, rm_rst=1 for RECOVER_CYCLES.
  - Then rm_rst=0 -> RUN if run=1, else IDLE.
  - The prescaler resumes from its frozen value.
- Address wrap: increment 0xFFF->0x000; decrement 0x000->0xFFF. Arithmetic is modulo 2^ADDR_W.
- upper/lower <= upper_in/lower_in every cycle in IDLE and RUN only; otherwise they hold.
- Simultaneous events:
  - reconfig_req wins over step_req and over the address tick; the step is dropped and addr is unchanged.
  - reconfig_req while busy is ignored.
  - reconfig_done outside DECOUPLED is ignored.
  - A dir change takes effect on the next tick.
- Reset mid-operation (any state): immediate return to reset values, decouple drops asynchronously, addr=0.

Optional Feature:
- Macro SHIFT_RP_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in DECOUPLED.
  - At TIMEOUT_CYCLES without reconfig_done -> RECOVER, and sticky output timeout_err (1 bit, reset 0) is set.
  - timeout_err clears only on rst.
- Undefined: no watchdog and no timeout_err port; DECOUPLED waits indefinitely.

Decomposition:
- Shared package shift_rp_pkg:
  - State enum: IDLE=0, RUN=1, DRAIN=2, DECOUPLED=3, RECOVER=4 (3-bit).
  - Default ADDR_W and data width 4.
- One sub-module, shift_rp_addr_gen: prescaler, address counter, direction, wrap and freeze input.
- The FSM, handshake and output registers stay in the top block.

Test Plan:
- Reset then run=1, PRESCALE_W=2, dir=0 -> addr 0,1,2,3 every 4 cycles; wraps 0xFFF->0x000 after 4096 ticks.
- IDLE, addr=0x000, dir=1, one step_req pulse -> addr=0xFFF next cycle, then stays constant.
- RUN, reconfig_req at addr=0x005 -> busy=1 at once, decouple=1 after 4 cycles, upper/lower frozen. reconfig_done -> decouple=0, rm_rst=1 for 2 cycles, back to RUN with addr continuing from 0x005.
- reconfig_req and step_req in the same IDLE cycle -> DRAIN entered, addr unchanged.
- rst asserted mid-DECOUPLED -> decouple=0 and reconfig_ack=0 without a clock edge, addr=0, upper=lower=0, rm_rst=1.
- With SHIFT_RP_TIMEOUT_EN and TIMEOUT_CYCLES=16, no reconfig_done -> RECOVER after 16 cycles, timeout_err=1 sticky until rst.

Source files
------------

// File: rtl/shift_rp_pkg.sv
// Shared types and defaults for the shift RP controller.
// State encoding is fixed so it can be probed from the static region.
package shift_rp_pkg;

   localparam int DEF_ADDR_W = 12;
   localparam int DATA_W     = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RUN       = 3'd1,
      DRAIN     = 3'd2,
      DECOUPLED = 3'd3,
      RECOVER   = 3'd4
   } state_t;

   function automatic logic is_busy(state_t s);
      return (s == DRAIN) || (s == DECOUPLED) || (s == RECOVER);
   endfunction

endpackage

// File: rtl/shift_rp_controller_if.sv
// Signal bundle between the static top and the shift RP controller.
// timeout_err exists only when SHIFT_RP_TIMEOUT_EN is defined.
interface shift_rp_controller_if
   import shift_rp_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);

   logic              run;
   logic              step_req;
   logic              dir;
   logic              reconfig_req;
   logic              reconfig_done;
   logic [DATA_W-1:0] upper_in;
   logic [DATA_W-1:0] lower_in;
   logic [ADDR_W-1:0] addr;
   logic              rm_rst;
   logic              decouple;
   logic              reconfig_ack;
   logic [DATA_W-1:0] upper;
   logic [DATA_W-1:0] lower;
   logic              busy;
`ifdef SHIFT_RP_TIMEOUT_EN
   logic              timeout_err;

   modport master (
      output run, step_req, dir,
      output reconfig_req, reconfig_done,
      output upper_in, lower_in,
      input  addr, rm_rst, decouple,
      input  reconfig_ack, upper, lower,
      input  busy, timeout_err
   );

   modport slave (
      input  run, step_req, dir,
      input  reconfig_req, reconfig_done,
      input  upper_in, lower_in,
      output addr, rm_rst, decouple,
      output reconfig_ack, upper, lower,
      output busy, timeout_err
   );
`else
   modport master (
      output run, step_req, dir,
      output reconfig_req, reconfig_done,
      output upper_in, lower_in,
      input  addr, rm_rst, decouple,
      input  reconfig_ack, upper, lower,
      input  busy
   );

   modport slave (
      input  run, step_req, dir,
      input  reconfig_req, reconfig_done,
      input  upper_in, lower_in,
      output addr, rm_rst, decouple,
      output reconfig_ack, upper, lower,
      output busy
   );
`endif

endinterface

// File: rtl/shift_rp_addr_gen.sv
// Prescaled up/down address counter shared by both shift RPs.
// freeze holds prescaler and address; clr zeroes only the prescaler.
module shift_rp_addr_gen #(
   parameter int ADDR_W     = 12,
   parameter int PRESCALE_W = 23
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_en,
   input  logic              step,
   input  logic              clr,
   input  logic              freeze,
   input  logic              dir,
   output logic [ADDR_W-1:0] addr
);

   logic [PRESCALE_W-1:0] pre_q;
   logic                  adv;

   assign adv = step || (tick_en && !clr && (&pre_q));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q <= '0;
         addr  <= '0;
      end else if (!freeze) begin
         if (clr)
            pre_q <= '0;
         else if (tick_en)
            pre_q <= pre_q + PRESCALE_W'(1);
         // modulo 2^ADDR_W in both directions
         if (adv)
            addr <= dir ? addr - ADDR_W'(1)
                        : addr + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/shift_rp_controller.sv
// Address sequencing and DFX reconfiguration handshake for the shift RPs.
// Define SHIFT_RP_TIMEOUT_EN to add the DECOUPLED watchdog and timeout_err.
module shift_rp_controller
   import shift_rp_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int PRESCALE_W     = 23,
   parameter int DRAIN_CYCLES   = 4,
   parameter int RECOVER_CYCLES = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic                  gclk,
   input logic                  rst,
   shift_rp_controller_if.slave bus
);

   localparam int CNT_MAX =
      (TIMEOUT_CYCLES > 255) ? TIMEOUT_CYCLES : 255;
   localparam int CNT_W = $clog2(CNT_MAX + 1);

   state_t            state_q;
   state_t            state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              cnt_inc;
   logic              tick_en;
   logic              step;
   logic              clr;
   logic              freeze;
   logic [ADDR_W-1:0] addr;
   logic              rm_rst_q;
   logic              dec_q;
   logic              ack_q;
   logic              busy_q;
   logic [DATA_W-1:0] upper_q;
   logic [DATA_W-1:0] lower_q;
`ifdef SHIFT_RP_TIMEOUT_EN
   logic              to_hit;
   logic              err_q;
`endif

   shift_rp_addr_gen #(
      .ADDR_W     (ADDR_W),
      .PRESCALE_W (PRESCALE_W)
   ) u_addr_gen (
      .clk     (gclk),
      .rst     (rst),
      .tick_en (tick_en),
      .step    (step),
      .clr     (clr),
      .freeze  (freeze),
      .dir     (bus.dir),
      .addr    (addr)
   );

   always_comb begin
      state_d = state_q;
      cnt_inc = 1'b0;
      tick_en = 1'b0;
      step    = 1'b0;
      clr     = 1'b0;
      freeze  = 1'b0;
`ifdef SHIFT_RP_TIMEOUT_EN
      to_hit  = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            clr = 1'b1;
            // a reconfig request swallows a coincident step
            if (bus.reconfig_req) begin
               state_d = DRAIN;
            end else begin
               step = bus.step_req;
               if (bus.run) state_d = RUN;
            end
         end
         RUN: begin
            if (bus.reconfig_req) begin
               state_d = DRAIN;
               freeze  = 1'b1;
            end else if (!bus.run) begin
               state_d = IDLE;
               clr     = 1'b1;
            end else begin
               tick_en = 1'b1;
            end
         end
         DRAIN: begin
            freeze  = 1'b1;
            cnt_inc = 1'b1;
            if (cnt_q == CNT_W'(DRAIN_CYCLES - 1))
               state_d = DECOUPLED;
         end
         DECOUPLED: begin
            freeze = 1'b1;
            if (bus.reconfig_done) begin
               state_d = RECOVER;
            end
`ifdef SHIFT_RP_TIMEOUT_EN
            else begin
               cnt_inc = 1'b1;
               if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_d = RECOVER;
                  to_hit  = 1'b1;
               end
            end
`endif
         end
         RECOVER: begin
            freeze  = 1'b1;
            cnt_inc = 1'b1;
            if (cnt_q == CNT_W'(RECOVER_CYCLES - 1))
               state_d = bus.run ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q)
         cnt_d = '0;
      else if (cnt_inc)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge gclk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rm_rst_q <= 1'b1;
         dec_q    <= 1'b0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         upper_q  <= '0;
         lower_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rm_rst_q <= (state_d == RECOVER);
         dec_q    <= (state_d == DECOUPLED);
         ack_q    <= (state_d == DECOUPLED);
         busy_q   <= is_busy(state_d);
         // capture only while the RPs are live
         if (state_q == IDLE || state_q == RUN) begin
            upper_q <= bus.upper_in;
            lower_q <= bus.lower_in;
         end
      end
   end

`ifdef SHIFT_RP_TIMEOUT_EN
   always_ff @(posedge gclk or posedge rst) begin
      if (rst)
         err_q <= 1'b0;
      else if (to_hit)
         err_q <= 1'b1;
   end

   assign bus.timeout_err = err_q;
`endif

   assign bus.addr         = addr;
   assign bus.rm_rst       = rm_rst_q;
   assign bus.decouple     = dec_q;
   assign bus.reconfig_ack = ack_q;
   assign bus.busy         = busy_q;
   assign bus.upper        = upper_q;
   assign bus.lower        = lower_q;

endmodule

// File: tb/tb_shift_rp_controller.sv
// Directed bench for shift_rp_controller with a 2-bit prescaler.
// Timeout checks run only when SHIFT_RP_TIMEOUT_EN is defined.
module tb_shift_rp_controller;

   localparam int AW = 12;

   typedef struct {
      logic       run;
      logic       step;
      logic       dir;
      logic       req;
      logic       done;
      logic [3:0] ui;
      logic [3:0] li;
      logic [11:0] ea;
      logic [3:0] eu;
      logic [3:0] el;
      logic       eb;
      logic       ed;
      logic       ek;
      logic       er;
   } vec_t;

   logic gclk = 1'b0;
   logic rst  = 1'b1;
   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 gclk = ~gclk;

   shift_rp_controller_if #(.ADDR_W(AW)) bus ();

   shift_rp_controller #(
      .ADDR_W         (AW),
      .PRESCALE_W     (2),
      .DRAIN_CYCLES   (4),
      .RECOVER_CYCLES (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .gclk (gclk),
      .rst  (rst),
      .bus  (bus)
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge gclk);
      #1;
   endtask

   task automatic idle_in();
      bus.run           = 1'b0;
      bus.step_req      = 1'b0;
      bus.dir           = 1'b0;
      bus.reconfig_req  = 1'b0;
      bus.reconfig_done = 1'b0;
      bus.upper_in      = 4'h0;
      bus.lower_in      = 4'h0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_in();
      repeat (2) tick();
      chk("rst addr", 32'(bus.addr), 0);
      chk("rst rm_rst", 32'(bus.rm_rst), 1);
      chk("rst decouple", 32'(bus.decouple), 0);
      chk("rst ack", 32'(bus.reconfig_ack), 0);
      chk("rst upper", 32'(bus.upper), 0);
      chk("rst lower", 32'(bus.lower), 0);
      chk("rst busy", 32'(bus.busy), 0);
      rst = 1'b0;
   endtask

   function automatic void add(
      input logic run, step, dir, req, done,
      input logic [3:0] ui, li,
      input logic [11:0] ea,
      input logic [3:0] eu, el,
      input logic eb, ed, ek, er);
      vec_t v;
      v.run = run;  v.step = step; v.dir = dir;
      v.req = req;  v.done = done;
      v.ui = ui;    v.li = li;     v.ea = ea;
      v.eu = eu;    v.el = el;     v.eb = eb;
      v.ed = ed;    v.ek = ek;     v.er = er;
      vecs.push_back(v);
   endfunction

   initial begin
      idle_in();
      // run step dir req done ui li | addr u l busy dec ack rm
      add(0,0,0,0,0,4'h3,4'h5, 12'h000,4'h3,4'h5,0,0,0,0);
      add(0,1,0,0,0,4'hA,4'h6, 12'h001,4'hA,4'h6,0,0,0,0);
      add(0,1,0,0,0,4'hA,4'h6, 12'h002,4'hA,4'h6,0,0,0,0);
      add(0,1,1,0,0,4'hA,4'h6, 12'h001,4'hA,4'h6,0,0,0,0);
      add(0,1,1,0,0,4'hA,4'h6, 12'h000,4'hA,4'h6,0,0,0,0);
      add(0,1,1,0,0,4'hA,4'h6, 12'hFFF,4'hA,4'h6,0,0,0,0);
      add(0,0,1,0,0,4'hA,4'h6, 12'hFFF,4'hA,4'h6,0,0,0,0);
      add(0,1,0,0,0,4'hA,4'h6, 12'h000,4'hA,4'h6,0,0,0,0);
      add(0,1,0,1,0,4'h1,4'h2, 12'h000,4'h1,4'h2,1,0,0,0);
      add(0,1,0,0,0,4'hF,4'hF, 12'h000,4'h1,4'h2,1,0,0,0);
      add(0,0,0,0,1,4'hF,4'hF, 12'h000,4'h1,4'h2,1,0,0,0);
      add(0,0,0,1,0,4'hF,4'hF, 12'h000,4'h1,4'h2,1,0,0,0);
      add(0,0,0,0,0,4'hF,4'hF, 12'h000,4'h1,4'h2,1,1,1,0);
      add(0,0,0,0,0,4'hF,4'hF, 12'h000,4'h1,4'h2,1,1,1,0);
      add(1,0,0,0,1,4'hF,4'hF, 12'h000,4'h1,4'h2,1,0,0,1);
      add(1,0,0,0,0,4'hF,4'hF, 12'h000,4'h1,4'h2,1,0,0,1);
      add(1,0,0,0,0,4'h7,4'h8, 12'h000,4'h1,4'h2,0,0,0,0);
      add(1,0,0,0,0,4'h7,4'h8, 12'h000,4'h7,4'h8,0,0,0,0);
      add(1,0,0,0,0,4'h7,4'h8, 12'h000,4'h7,4'h8,0,0,0,0);
      add(1,0,0,0,0,4'h7,4'h8, 12'h000,4'h7,4'h8,0,0,0,0);
      add(1,0,0,0,0,4'h7,4'h8, 12'h001,4'h7,4'h8,0,0,0,0);
      add(0,0,0,0,0,4'h7,4'h8, 12'h001,4'h7,4'h8,0,0,0,0);

      do_reset();
      foreach (vecs[i]) begin
         bus.run           = vecs[i].run;
         bus.step_req      = vecs[i].step;
         bus.dir           = vecs[i].dir;
         bus.reconfig_req  = vecs[i].req;
         bus.reconfig_done = vecs[i].done;
         bus.upper_in      = vecs[i].ui;
         bus.lower_in      = vecs[i].li;
         tick();
         chk($sformatf("row%0d addr", i),
             32'(bus.addr), 32'(vecs[i].ea));
         chk($sformatf("row%0d upper", i),
             32'(bus.upper), 32'(vecs[i].eu));
         chk($sformatf("row%0d lower", i),
             32'(bus.lower), 32'(vecs[i].el));
         chk($sformatf("row%0d busy", i),
             32'(bus.busy), 32'(vecs[i].eb));
         chk($sformatf("row%0d decouple", i),
             32'(bus.decouple), 32'(vecs[i].ed));
         chk($sformatf("row%0d ack", i),
             32'(bus.reconfig_ack), 32'(vecs[i].ek));
         chk($sformatf("row%0d rm_rst", i),
             32'(bus.rm_rst), 32'(vecs[i].er));
      end
      idle_in();

      // asynchronous reset while decoupled
      bus.reconfig_req = 1'b1;
      tick();
      bus.reconfig_req = 1'b0;
      repeat (4) tick();
      chk("pre-rst decouple", 32'(bus.decouple), 1);
      #2 rst = 1'b1;
      #1;
      chk("async decouple", 32'(bus.decouple), 0);
      chk("async ack", 32'(bus.reconfig_ack), 0);
      chk("async addr", 32'(bus.addr), 0);
      chk("async upper", 32'(bus.upper), 0);
      chk("async lower", 32'(bus.lower), 0);
      chk("async rm_rst", 32'(bus.rm_rst), 1);
      chk("async busy", 32'(bus.busy), 0);

      // free run: one tick every 4 cycles, then full wrap
      do_reset();
      bus.run = 1'b1;
      tick();
      chk("run start addr", 32'(bus.addr), 0);
      for (int k = 1; k <= 3; k++) begin
         repeat (3) tick();
         chk($sformatf("run hold %0d", k),
             32'(bus.addr), 32'(k - 1));
         tick();
         chk($sformatf("run tick %0d", k),
             32'(bus.addr), 32'(k));
      end
      repeat (16368) tick();
      chk("run at fff", 32'(bus.addr), 32'h0FFF);
      repeat (3) tick();
      chk("run hold fff", 32'(bus.addr), 32'h0FFF);
      tick();
      chk("run wrap", 32'(bus.addr), 0);

      // reconfiguration out of RUN at addr 5
      do_reset();
      bus.run      = 1'b1;
      bus.upper_in = 4'h4;
      bus.lower_in = 4'h4;
      repeat (21) tick();
      chk("rc addr5", 32'(bus.addr), 5);
      bus.reconfig_req = 1'b1;
      tick();
      bus.reconfig_req = 1'b0;
      bus.upper_in     = 4'hC;
      bus.lower_in     = 4'hC;
      chk("rc busy", 32'(bus.busy), 1);
      chk("rc dec early", 32'(bus.decouple), 0);
      repeat (3) tick();
      chk("rc dec 3", 32'(bus.decouple), 0);
      tick();
      chk("rc dec 4", 32'(bus.decouple), 1);
      chk("rc ack", 32'(bus.reconfig_ack), 1);
      chk("rc upper frz", 32'(bus.upper), 4);
      chk("rc lower frz", 32'(bus.lower), 4);
      chk("rc addr frz", 32'(bus.addr), 5);
      bus.reconfig_done = 1'b1;
      tick();
      bus.reconfig_done = 1'b0;
      chk("rc rec dec", 32'(bus.decouple), 0);
      chk("rc rec ack", 32'(bus.reconfig_ack), 0);
      chk("rc rec rm1", 32'(bus.rm_rst), 1);
      tick();
      chk("rc rec rm2", 32'(bus.rm_rst), 1);
      tick();
      chk("rc back rm", 32'(bus.rm_rst), 0);
      chk("rc back busy", 32'(bus.busy), 0);
      chk("rc back upper", 32'(bus.upper), 4);
      tick();
      chk("rc live upper", 32'(bus.upper), 32'hC);
      repeat (2) tick();
      chk("rc resume hold", 32'(bus.addr), 5);
      tick();
      chk("rc resume tick", 32'(bus.addr), 6);

`ifdef SHIFT_RP_TIMEOUT_EN
      do_reset();
      chk("to err rst", 32'(bus.timeout_err), 0);
      bus.reconfig_req = 1'b1;
      tick();
      bus.reconfig_req = 1'b0;
      repeat (4) tick();
      chk("to dec", 32'(bus.decouple), 1);
      repeat (15) tick();
      chk("to dec 15", 32'(bus.decouple), 1);
      chk("to err 15", 32'(bus.timeout_err), 0);
      tick();
      chk("to dec 16", 32'(bus.decouple), 0);
      chk("to rm 16", 32'(bus.rm_rst), 1);
      chk("to err set", 32'(bus.timeout_err), 1);
      repeat (4) tick();
      chk("to idle busy", 32'(bus.busy), 0);
      chk("to err sticky", 32'(bus.timeout_err), 1);
      rst = 1'b1;
      #1;
      chk("to err clr", 32'(bus.timeout_err), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
